// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus unit.
// The FSM state encoding, RV32I funct3 codes and request legality check live here.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_R,
      ST_RESP
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Wide enough for the largest supported MAX_WAIT of 1023.
   localparam int WAIT_W = 10;

   function automatic logic req_error(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
      logic err;
      case (f3)
         F3_B, F3_BU: err = 1'b0;
         F3_H, F3_HU: err = addr_lo[0];
         F3_W:        err = (addr_lo != 2'b00);
         default:     err = 1'b1;
      endcase
      if (is_store && f3 == 3'b111) begin
         err = 1'b1;
      end
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes and replication, plus load lane
// extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] lane;

   always_comb begin
      wstrb_o = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = '0;
      lane    = rdata_i >> {addr_lo_i, 3'b000};

      case (funct3_i[1:0])
         2'b00: begin
            wstrb_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            wstrb_o = 4'b0011 << addr_lo_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            wstrb_o = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase

      case (funct3_i)
         F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
         F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   rdata_o = {24'h0, lane[7:0]};
         F3_HU:   rdata_o = {16'h0, lane[15:0]};
         default: rdata_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_bus.sv
// Memory-stage load/store unit: accepts one request at a time, runs a single
// bus transaction with a timeout, and returns a one-cycle response pulse.
module lsu_bus
   import lsu_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [2:0]        al_funct3;
   logic [1:0]        al_addr_lo;
   logic [3:0]        al_wstrb;
   logic [31:0]       al_wdata;
   logic [31:0]       al_rdata;
   logic              timeout;

   // One aligner serves both directions: live request fields while idle
   // (store formatting), captured fields afterwards (load extension).
   assign al_funct3  = (state_q == ST_IDLE) ? req_funct3    : funct3_q;
   assign al_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;
   assign timeout    = (cnt_q == WAIT_W'(MAX_WAIT - 1));

   lsu_align u_align (
      .funct3_i  (al_funct3),
      .addr_lo_i (al_addr_lo),
      .wdata_i   (req_wdata),
      .rdata_i   (mem_rdata),
      .wstrb_o   (al_wstrb),
      .wdata_o   (al_wdata),
      .rdata_o   (al_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      mem_valid_d = mem_valid_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               funct3_d  = req_funct3;
               addr_lo_d = req_addr[1:0];
               if (req_error(req_write, req_funct3, req_addr[1:0])) begin
                  state_d   = ST_RESP;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = '0;
                  mem_valid_d = 1'b1;
                  mem_we_d    = req_write;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_wstrb_d = req_write ? al_wstrb : 4'b0000;
                  mem_wdata_d = req_write ? al_wdata : 32'h0;
               end
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               if (mem_we_q) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT_R;
                  cnt_d   = '0;
               end
            end else if (timeout) begin
               mem_valid_d = 1'b0;
               state_d     = ST_RESP;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_R: begin
            if (mem_rvalid) begin
               state_d     = ST_RESP;
               rsp_rdata_d = al_rdata;
            end else if (timeout) begin
               state_d   = ST_RESP;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = ~req_ready;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: stores, loads, errors, timeouts, reset abort
// and back-to-back requests, each checked against hand-computed values.
module tb_lsu_bus;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   lsu_bus #(.MAX_WAIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits (bounded) for the unit to be idle at a falling edge.
   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Issues one request, scrambles req_* after acceptance, then follows the
   // transaction for up to 20 cycles. lat = cycle index of rsp_valid (1 = the
   // cycle right after the acceptance edge), 0 if no response was seen.
   task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output logic sawv, output logic [31:0] maddr,
                          output logic [3:0] mstrb, output logic [31:0] mwd,
                          output logic mwe);
      lat = 0; rd = '0; er = 1'b0; sawv = 1'b0;
      maddr = '0; mstrb = '0; mwd = '0; mwe = 1'b0;
      wait_idle();
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b111;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         if (mem_valid && !sawv) begin
            sawv = 1'b1; maddr = mem_addr; mstrb = mem_wstrb; mwd = mem_wdata; mwe = mem_we;
         end
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; er = rsp_err;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({req_ready, busy, rsp_valid, rsp_err, mem_valid, mem_we} !== 6'b100000) begin
         fails++;
         $display("[TB] FAIL reset_ctrl: got %b expected 100000",
                  {req_ready, busy, rsp_valid, rsp_err, mem_valid, mem_we});
      end
      tests++;
      if ({rsp_rdata, mem_addr, mem_wstrb, mem_wdata} !== 100'h0) begin
         fails++;
         $display("[TB] FAIL reset_data: got %h %h %h %h expected all zero",
                  rsp_rdata, mem_addr, mem_wstrb, mem_wdata);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_stores();
      logic [31:0] vaddr [3] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
      logic [2:0]  vf3   [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] vwd   [3] = '{32'h0000_00A5, 32'hDEAD_BEEF, 32'h0123_4567};
      logic [31:0] emaddr[3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
      logic [3:0]  estrb [3] = '{4'b1000, 4'b1100, 4'b1111};
      logic [31:0] ewd   [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h0123_4567};
      int lat; logic [31:0] rd; logic er, sawv, mwe; logic [31:0] maddr, mwd; logic [3:0] mstrb;
      mem_ready = 1'b1; mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b1, vf3[i], vaddr[i], vwd[i], lat, rd, er, sawv, maddr, mstrb, mwd, mwe);
         tests++;
         if ({sawv, mwe, maddr, mstrb, mwd} !== {1'b1, 1'b1, emaddr[i], estrb[i], ewd[i]}) begin
            fails++;
            $display("[TB] FAIL store%0d_bus: got v=%b we=%b a=%h s=%b d=%h expected v=1 we=1 a=%h s=%b d=%h",
                     i, sawv, mwe, maddr, mstrb, mwd, emaddr[i], estrb[i], ewd[i]);
         end
         tests++;
         if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            fails++;
            $display("[TB] FAIL store%0d_rsp: got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=0",
                     i, lat, er, rd);
         end
      end
   endtask

   task automatic test_loads();
      logic [2:0]  vf3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] vaddr[6] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h3000, 32'h2003};
      logic [31:0] vmem [6] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000,
                                32'h8001_0000, 32'h1234_5678, 32'h7F00_0000};
      logic [31:0] exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                32'h0000_8001, 32'h1234_5678, 32'h0000_007F};
      int lat; logic [31:0] rd; logic er, sawv, mwe; logic [31:0] maddr, mwd; logic [3:0] mstrb;
      mem_ready = 1'b1; mem_rvalid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_rdata = vmem[i];
         run_txn(1'b0, vf3[i], vaddr[i], 32'hFFFF_FFFF, lat, rd, er, sawv, maddr, mstrb, mwd, mwe);
         tests++;
         if (rd !== exp[i] || er !== 1'b0 || lat !== 3) begin
            fails++;
            $display("[TB] FAIL load%0d: got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=3",
                     i, rd, er, lat, exp[i]);
         end
         tests++;
         if ({sawv, mwe, mstrb, maddr} !== {1'b1, 1'b0, 4'b0000, vaddr[i] & 32'hFFFF_FFFC}) begin
            fails++;
            $display("[TB] FAIL load%0d_bus: got v=%b we=%b s=%b a=%h expected v=1 we=0 s=0000 a=%h",
                     i, sawv, mwe, mstrb, maddr, vaddr[i] & 32'hFFFF_FFFC);
         end
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_errors();
      logic        vw   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0]  vf3  [5] = '{3'b010, 3'b001, 3'b011, 3'b111, 3'b101};
      logic [31:0] vaddr[5] = '{32'h3002, 32'h2001, 32'h2000, 32'h2000, 32'h2003};
      int lat; logic [31:0] rd; logic er, sawv, mwe; logic [31:0] maddr, mwd; logic [3:0] mstrb;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         run_txn(vw[i], vf3[i], vaddr[i], 32'h1111_2222, lat, rd, er, sawv, maddr, mstrb, mwd, mwe);
         tests++;
         if (er !== 1'b1 || lat !== 1 || sawv !== 1'b0 || rd !== 32'h0) begin
            fails++;
            $display("[TB] FAIL err%0d: got err=%b lat=%0d memv=%b rdata=%h expected err=1 lat=1 memv=0 rdata=0",
                     i, er, lat, sawv, rd);
         end
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_timeout();
      int lat; logic [31:0] rd; logic er, sawv, mwe; logic [31:0] maddr, mwd; logic [3:0] mstrb;
      logic late_rsp;
      // Bus never answers the request: four REQ cycles, then error.
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      run_txn(1'b0, 3'b010, 32'h4000, 32'h0, lat, rd, er, sawv, maddr, mstrb, mwd, mwe);
      tests++;
      if (lat !== 5 || er !== 1'b1 || sawv !== 1'b1 || mem_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL req_timeout: got lat=%0d err=%b sawv=%b memv_now=%b expected lat=5 err=1 sawv=1 memv_now=0",
                  lat, er, sawv, mem_valid);
      end
      // mem_ready arrives on the last REQ cycle: handshake beats the timeout.
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      wait_idle();
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      tests++;
      if (mem_valid !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL req_cycle4: got memv=%b rspv=%b expected memv=1 rspv=0", mem_valid, rsp_valid);
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
         fails++;
         $display("[TB] FAIL ready_wins: got rspv=%b err=%b rdata=%h expected rspv=1 err=0 rdata=cafef00d",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      // Read data never returns: four WAIT_R cycles, then error; late data ignored.
      mem_ready = 1'b1; mem_rvalid = 1'b0;
      run_txn(1'b0, 3'b010, 32'h4020, 32'h0, lat, rd, er, sawv, maddr, mstrb, mwd, mwe);
      tests++;
      if (lat !== 6 || er !== 1'b1 || rd !== 32'h0) begin
         fails++;
         $display("[TB] FAIL rd_timeout: got lat=%0d err=%b rdata=%h expected lat=6 err=1 rdata=0", lat, er, rd);
      end
      mem_rvalid = 1'b1;
      late_rsp = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid) late_rsp = 1'b1;
      end
      tests++;
      if (late_rsp !== 1'b0) begin
         fails++;
         $display("[TB] FAIL late_rvalid: got rsp_valid seen=%b expected 0", late_rsp);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      logic spurious;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h9999_9999;
      wait_idle();
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      tests++;
      if ({req_ready, busy, rsp_valid, rsp_err, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_rdata}
          !== {6'b100000, 100'h0}) begin
         fails++;
         $display("[TB] FAIL async_reset: got rdy=%b busy=%b memv=%b addr=%h expected rdy=1 busy=0 memv=0 addr=0",
                  req_ready, busy, mem_valid, mem_addr);
      end
      @(negedge clk);
      reset = 1'b1;
      mem_rvalid = 1'b1;
      spurious = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rsp_valid || !req_ready) spurious = 1'b1;
      end
      tests++;
      if (spurious !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_abandon: got activity=%b expected 0", spurious);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_busy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic exp_rsp  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] bad;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
      wait_idle();
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h6000; req_wdata = 32'hAAAA_5555;
      bad = 2'b00;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            req_write = 1'b0; req_addr = 32'h6004;
         end
         if (c == 5) req_valid = 1'b0;
         if (busy !== exp_busy[c] || rsp_valid !== exp_rsp[c]) begin
            bad[0] = 1'b1;
            $display("[TB] FAIL b2b_cycle%0d: got busy=%b rspv=%b expected busy=%b rspv=%b",
                     c + 1, busy, rsp_valid, exp_busy[c], exp_rsp[c]);
         end
         if (c == 3 && (mem_addr !== 32'h6004 || mem_we !== 1'b0)) bad[1] = 1'b1;
      end
      tests++;
      if (bad[0] !== 1'b0) fails++;
      tests++;
      if (bad[1] !== 1'b0 || rsp_rdata !== 32'h1122_3344) begin
         fails++;
         $display("[TB] FAIL b2b_load: got rdata=%h busfault=%b expected rdata=11223344 busfault=0",
                  rsp_rdata, bad[1]);
      end
      mem_rvalid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      test_reset();
      test_stores();
      test_loads();
      test_errors();
      test_timeout();
      test_reset_midflight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter: MAX_WAIT, 255, bus-wait cycles before timeout error (1..1023).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  memory-stage request present.
REQ-005 req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, in the low bits.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid.
REQ-013 busy  out  1  pipeline stall; equals !req_ready.
REQ-014 mem_valid / mem_ready  out / in  1 / 1  bus request handshake.
REQ-015 mem_we  out  1  bus write enable.
REQ-016 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-017 mem_wstrb  out  4  byte-lane strobes.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rvalid / mem_rdata  in / in  1 / 32  read-data return.

Function
REQ-020 FSM states: IDLE, REQ, WAIT_R, RESP; req_ready=1 only in IDLE.
REQ-021 On acceptance, capture req_write, req_funct3, req_addr and req_wdata; later changes on req_* have no effect.
REQ-022 Error check at acceptance; error if:
- funct3 is 011, 110 or 111;
- funct3 is 111 for a store;
- a halfword access has addr[0]=1;
- a word access has addr[1:0]!=0.
REQ-023 On error: IDLE->RESP with no bus transaction and mem_valid kept 0.
REQ-024 Otherwise IDLE->REQ; mem_valid=1 and mem_* remain stable until the cycle mem_ready=1.
REQ-025 REQ with mem_ready=1: store -> RESP; load -> WAIT_R.
REQ-026 mem_rvalid is sampled only in WAIT_R; mem_rdata is captured on mem_rvalid=1, then WAIT_R->RESP.
REQ-027 Strobes: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111. Loads drive mem_wstrb=0 and mem_we=0.
REQ-028 Store data: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-029 Load data: lane = rdata >> (8*addr[1:0]).
- lb/lh sign-extend bit 7/15.
- lbu/lhu zero-extend.
- lw passes the word.
REQ-030 RESP lasts exactly one cycle with rsp_valid=1, then goes to IDLE; the next request can be accepted the cycle after RESP.
REQ-031 Minimum latency from the acceptance edge to rsp_valid: store 2 cycles; load 3 cycles; error 1 cycle.
REQ-032 A wait counter clears on entry to REQ and to WAIT_R, and increments every cycle in those states.
REQ-033 When the wait counter reaches MAX_WAIT without the awaited handshake, go to RESP with rsp_err=1.
- mem_valid drops in the same cycle.
- A late mem_rvalid is ignored.
REQ-034 mem_ready and the timeout in the same cycle: the handshake wins.
REQ-035 rsp_rdata, rsp_err and mem_* outputs are registered; mem_valid has no combinational path from req_valid.

Reset
REQ-036 reset=0 forces IDLE immediately, from any state including mid-transaction; a pending transaction is abandoned with no response.
REQ-037 Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, counter=0.

Structure
REQ-038 Package lsu_pkg holds:
- the state enum;
- funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
- the MAX_WAIT width constant.
REQ-039 One combinational sub-module, lsu_align, holds the strobe, replication and load-extension logic shared by both data directions.

Verification
REQ-040 sb, addr=0x1003, wdata=0x000000A5, mem_ready=1 at once -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, rsp_valid 2 cycles after acceptance.
REQ-041 lb, addr=0x2001, rdata=0x0000_8000 -> rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080; lh addr=0x2002, rdata=0x8001_0000 -> 0xFFFF8001.
REQ-042 lw, addr=0x3002 -> rsp_err=1 one cycle after acceptance, mem_valid never asserted.
REQ-043 MAX_WAIT=4, load with mem_ready held 0 -> rsp_err=1 after 4 REQ cycles; mem_ready=1 on the 4th cycle -> normal load completes.
REQ-044 reset=0 asserted in WAIT_R -> outputs take reset values asynchronously; a later mem_rvalid produces no rsp_valid.
REQ-045 Back-to-back sw then lw with req_valid held high -> second acceptance in the cycle after the first rsp_valid; busy=1 throughout each transaction.
